matmult_feeder: RTL and testbench
=================================

Name: matmult_feeder

Overview:
- Host-side driver for the 8x8 matrix-multiply engine. It is the transmitter for the engine's row-load interface and the receiver for its result.
- Accepts 16 64-bit row words on a valid/ready stream: 8 rows of A, then 8 rows of B.
- Drives matching A/B row writes and a start pulse into the engine, waits for done, then captures the 256-bit result.
- Returns the result as four 64-bit words on a valid/ready output stream. Sits between the host bus adapter and the engine.

Parameters:
ROWS, 8, rows per matrix; address width is clog2(ROWS)=3
DATA_W, 64, row word width (8 x 8-bit elements)
RES_W, 256, engine result width; RES_W/DATA_W = 4 output beats
TIMEOUT_CYC, 4096, max cycles in WAIT before error abort

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
clr  in  1  synchronous soft clear: abort to LOAD_A, clears err
s_valid  in  1  input row word valid
s_ready  out  1  feeder accepts input word
s_data  in  64  row word, byte 0 = column 0
mm_valid  out  1  row write strobe to engine
mm_addra  out  3  A row index
mm_inpa  out  64  A row data
mm_addrb  out  3  B row index
mm_inpb  out  64  B row data
mm_start  out  1  one-cycle compute start
mm_c  in  256  engine result
mm_done  in  1  engine result valid (pulse)
m_valid  out  1  result beat valid
m_ready  in  1  downstream accepts beat
m_data  out  64  result beat
m_last  out  1  marks 4th beat
busy  out  1  high in every state except LOAD_A with row count 0
err  out  1  sticky timeout flag

Behaviour:
- Reset (rst low, async):
  - State goes to LOAD_A; row count, beat index and timeout counter go to 0.
  - All outputs are 0 except s_ready, which goes to 1 once reset is released.
  - A buffer contents are don't-care.
- LOAD_A:
  - s_ready=1. On each handshake, abuf[cnt] <= s_data and cnt++.
  - The handshake at cnt=7 moves to LOAD_B with cnt=0.
  - No mm_* activity in this state.
- LOAD_B:
  - s_ready=1. A handshake at cycle N produces, at cycle N+1 (registered): mm_valid=1, mm_addra=mm_addrb=cnt, mm_inpa=abuf[cnt], mm_inpb=s_data(N).
  - mm_valid=0 in any cycle not following a handshake; gaps in s_valid are allowed.
  - The handshake at cnt=7 moves to START.
- START:
  - s_ready=0. mm_start=1 for exactly one cycle, at N+2 relative to the last B handshake.
  - mm_valid=0 in the same cycle.
  - Then move to WAIT with the timeout counter at 0.
- WAIT:
  - s_ready=0; the counter increments each cycle.
  - mm_done=1: register res <= mm_c and move to SEND with beat index 0. The first m_valid appears on the next cycle.
  - Counter reaching TIMEOUT_CYC-1 without done: err <= 1, move to LOAD_A, cnt=0.
  - If done and timeout occur in the same cycle, done wins.
- SEND:
  - m_valid=1, m_data=res[64*idx +: 64] (low word first), m_last=(idx==3).
  - m_data is held stable while m_ready=0.
  - A handshake increments idx; the handshake at idx 3 moves to LOAD_A with m_valid=0 the next cycle.
- mm_done outside WAIT is ignored; res does not change.
- clr (synchronous, in any state):
  - Next state is LOAD_A with cnt=idx=0, err=0.
  - m_valid, mm_valid and mm_start are 0 the next cycle. A pending result is discarded.
  - clr has priority over every other transition, including mm_done in the same cycle.
- err is sticky until clr or reset. A new transaction may run while err=1.
- Reset asserted mid-operation aborts immediately; partial loads and results are lost.

Decomposition:
- Shared package (mm_pkg): ROWS, DATA_W, RES_W, ADDR_W=3, BEATS=4, and the state enum {LOAD_A, LOAD_B, START, WAIT, SEND}.
- Sub-module mm_row_buf: 8x64 register file, one write port, one read port. Async read is allowed because its address is registered.
- All other logic (FSM, counters, output registers) lives in the top.

Test Plan:
1. Reset, then release -> all outputs 0 except s_ready=1; busy=0, err=0.
2. Load A rows 64'h0101..01*(i+1) and B rows 64'hF0..00+i, with no gaps:
   - mm_valid on 8 consecutive cycles.
   - mm_addra=mm_addrb=0..7; mm_inpa/mm_inpb match the loaded rows.
   - mm_start pulses exactly once, 2 cycles after the last B handshake.
3. In WAIT, drive mm_c=256'h4444..._3333..._2222..._1111... with a done pulse; hold m_ready=0 for 3 cycles, then toggle it:
   - Beats come out 64'h1111.., 2222.., 3333.., 4444.. in that order.
   - m_last is set only on the 4th beat; data stays stable under backpressure.
4. Random s_valid gaps during LOAD_B -> mm_valid appears only the cycle after each handshake; the row order is preserved.
5. Never assert mm_done -> err=1 after 4096 WAIT cycles; state returns to LOAD_A with s_ready=1; the next transaction still completes.
6. Assert clr after the 3rd B row; separately, assert reset low mid-SEND:
   - No mm_start pulse; err=0; the next load starts at row 0.
   - After reset, all outputs are at reset values with no further beats.

Source files
------------

// File: rtl/mm_pkg.sv
// Shared sizes and FSM state encoding for the matrix-multiply engine feeder.
package mm_pkg;
  localparam int ROWS        = 8;
  localparam int DATA_W      = 64;
  localparam int RES_W       = 256;
  localparam int ADDR_W      = $clog2(ROWS);
  localparam int BEATS       = RES_W / DATA_W;
  localparam int IDX_W       = $clog2(BEATS);
  localparam int TIMEOUT_CYC = 4096;
  localparam int TMO_W       = $clog2(TIMEOUT_CYC);

  typedef enum logic [2:0] {LOAD_A, LOAD_B, START, WAIT, SEND} state_t;
endpackage

// File: rtl/mm_row_buf.sv
// Row store for matrix A: one write port, combinational read (address is registered upstream).
module mm_row_buf
  import mm_pkg::*;
(
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);
  logic [DATA_W-1:0] mem [ROWS];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];
endmodule

// File: rtl/matmult_feeder.sv
// Host-side driver for the 8x8 matrix-multiply engine: streams A/B rows in,
// fires start, waits for done and streams the 256-bit result back out.
module matmult_feeder
  import mm_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              mm_valid,
  output logic [ADDR_W-1:0] mm_addra,
  output logic [DATA_W-1:0] mm_inpa,
  output logic [ADDR_W-1:0] mm_addrb,
  output logic [DATA_W-1:0] mm_inpb,
  output logic              mm_start,
  input  logic [RES_W-1:0]  mm_c,
  input  logic              mm_done,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              busy,
  output logic              err
);
  localparam logic [ADDR_W-1:0] ROW_LAST  = ADDR_W'(ROWS - 1);
  localparam logic [IDX_W-1:0]  BEAT_LAST = IDX_W'(BEATS - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYC - 1);

  state_t             state;
  logic [ADDR_W-1:0]  cnt;
  logic [IDX_W-1:0]   idx;
  logic [IDX_W-1:0]   idx_nx;
  logic [TMO_W-1:0]   tmo;
  logic [RES_W-1:0]   res;
  logic [DATA_W-1:0]  a_row;
  logic               s_hs;
  logic               m_hs;

  assign s_hs   = s_valid && s_ready;
  assign m_hs   = m_valid && m_ready;
  assign idx_nx = idx + 1'b1;
  assign busy   = !(state == LOAD_A && cnt == '0);

  mm_row_buf u_abuf (
    .clk     (clk),
    .wr_en   (s_hs && state == LOAD_A),
    .wr_addr (cnt),
    .wr_data (s_data),
    .rd_addr (cnt),
    .rd_data (a_row)
  );

  // Result capture needs no reset; it is only read after a fresh capture.
  always_ff @(posedge clk) begin
    if (!clr && state == WAIT && mm_done) res <= mm_c;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= LOAD_A;
      cnt      <= '0;
      idx      <= '0;
      tmo      <= '0;
      err      <= 1'b0;
      s_ready  <= 1'b0;
      mm_valid <= 1'b0;
      mm_addra <= '0;
      mm_addrb <= '0;
      mm_inpa  <= '0;
      mm_inpb  <= '0;
      mm_start <= 1'b0;
      m_valid  <= 1'b0;
      m_data   <= '0;
      m_last   <= 1'b0;
    end else begin
      mm_valid <= 1'b0;
      mm_start <= 1'b0;
      if (clr) begin
        state   <= LOAD_A;
        cnt     <= '0;
        idx     <= '0;
        tmo     <= '0;
        err     <= 1'b0;
        s_ready <= 1'b1;
        m_valid <= 1'b0;
        m_last  <= 1'b0;
      end else begin
        case (state)
          LOAD_A: begin
            s_ready <= 1'b1;
            if (s_hs) begin
              cnt <= (cnt == ROW_LAST) ? '0 : cnt + 1'b1;
              if (cnt == ROW_LAST) state <= LOAD_B;
            end
          end
          LOAD_B: begin
            if (s_hs) begin
              mm_valid <= 1'b1;
              mm_addra <= cnt;
              mm_addrb <= cnt;
              mm_inpa  <= a_row;
              mm_inpb  <= s_data;
              cnt      <= (cnt == ROW_LAST) ? '0 : cnt + 1'b1;
              if (cnt == ROW_LAST) begin
                state   <= START;
                s_ready <= 1'b0;
              end
            end
          end
          START: begin
            mm_start <= 1'b1;
            tmo      <= '0;
            state    <= WAIT;
          end
          WAIT: begin
            // done beats a coincident timeout
            if (mm_done) begin
              idx     <= '0;
              m_valid <= 1'b1;
              m_data  <= mm_c[DATA_W-1:0];
              m_last  <= 1'b0;
              state   <= SEND;
            end else if (tmo == TMO_LAST) begin
              err     <= 1'b1;
              cnt     <= '0;
              s_ready <= 1'b1;
              state   <= LOAD_A;
            end else begin
              tmo <= tmo + 1'b1;
            end
          end
          SEND: begin
            if (m_hs) begin
              if (idx == BEAT_LAST) begin
                m_valid <= 1'b0;
                m_last  <= 1'b0;
                s_ready <= 1'b1;
                state   <= LOAD_A;
              end else begin
                idx    <= idx_nx;
                m_data <= res[DATA_W*idx_nx +: DATA_W];
                m_last <= (idx_nx == BEAT_LAST);
              end
            end
          end
          default: state <= LOAD_A;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_matmult_feeder.sv
// Scoreboard bench for matmult_feeder: driver pushes expected engine writes and
// result beats; a negedge monitor pops and compares whatever the DUT presents.
module tb_matmult_feeder;
  logic         clk = 1'b0, rst = 1'b0, clr = 1'b0;
  logic         s_valid = 1'b0, mm_done = 1'b0, m_ready = 1'b0;
  logic [63:0]  s_data = '0;
  logic [255:0] mm_c = '0;
  logic         s_ready, mm_valid, mm_start, m_valid, m_last, busy, err;
  logic [2:0]   mm_addra, mm_addrb;
  logic [63:0]  mm_inpa, mm_inpb, m_data;

  matmult_feeder dut (
    .clk(clk), .rst(rst), .clr(clr),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .mm_valid(mm_valid), .mm_addra(mm_addra), .mm_inpa(mm_inpa),
    .mm_addrb(mm_addrb), .mm_inpb(mm_inpb), .mm_start(mm_start),
    .mm_c(mm_c), .mm_done(mm_done),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  typedef struct { logic [2:0] addr; logic [63:0] a; logic [63:0] b; } row_t;
  typedef struct { logic [63:0] d; logic last; } beat_t;

  row_t  rq[$];
  beat_t bq[$];
  int    exp_start = -1;
  int    starts_seen = 0;
  int    last_start_cyc = 0;
  int    compared = 0, mismatched = 0;
  logic [63:0] A [8];
  logic [63:0] B [8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Monitor: engine writes, start pulse timing, result beats.
  always @(negedge clk) begin
    row_t r;
    if (mm_valid) begin
      if (rq.size() == 0) chk("spurious_mm_valid", 64'(mm_valid), 64'd0);
      else begin
        r = rq.pop_front();
        chk("mm_addra", 64'(mm_addra), 64'(r.addr));
        chk("mm_addrb", 64'(mm_addrb), 64'(r.addr));
        chk("mm_inpa", mm_inpa, r.a);
        chk("mm_inpb", mm_inpb, r.b);
      end
    end else if (rq.size() != 0) begin
      chk("missing_mm_valid", 64'(mm_valid), 64'd1);
      void'(rq.pop_front());
    end
    if (mm_start) begin
      chk("mm_start_cycle", 64'(cycle), 64'(exp_start));
      chk("mm_valid_with_start", 64'(mm_valid), 64'd0);
      exp_start = -1;
      starts_seen++;
      last_start_cyc = cycle;
    end else if (exp_start >= 0 && cycle >= exp_start) begin
      chk("missing_mm_start", 64'(mm_start), 64'd1);
      exp_start = -1;
    end
    if (m_valid) begin
      if (bq.size() == 0) chk("spurious_beat", 64'(m_valid), 64'd0);
      else begin
        chk("m_data", m_data, bq[0].d);
        chk("m_last", 64'(m_last), 64'(bq[0].last));
        if (m_ready) void'(bq.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [63:0] d, output int hs_cyc);
    bit got = 0;
    s_valid = 1'b1;
    s_data  = d;
    hs_cyc  = -1;
    for (int t = 0; t < 64 && !got; t++) begin
      @(negedge clk);
      if (s_ready) begin
        got    = 1;
        hs_cyc = cycle;
      end
      tick();
    end
    s_valid = 1'b0;
    if (!got) chk("s_ready_timeout", 64'(s_ready), 64'd1);
  endtask

  task automatic load(input int nb, input bit gaps);
    int   hc;
    row_t r;
    for (int i = 0; i < 8; i++) begin
      send_word(A[i], hc);
      if (gaps) repeat ($urandom_range(0, 2)) tick();
    end
    for (int i = 0; i < nb; i++) begin
      send_word(B[i], hc);
      r.addr = 3'(i);
      r.a    = A[i];
      r.b    = B[i];
      rq.push_back(r);
      if (i == 7) exp_start = hc + 2;
      if (gaps) repeat ($urandom_range(0, 3)) tick();
    end
  endtask

  task automatic wait_start(input int prev);
    for (int t = 0; t < 16 && starts_seen == prev; t++) @(posedge clk);
    chk("start_count", 64'(starts_seen - prev), 64'd1);
  endtask

  task automatic fire_done(input logic [255:0] c);
    beat_t b;
    #1;
    mm_c    = c;
    mm_done = 1'b1;
    for (int k = 0; k < 4; k++) begin
      b.d    = c[64*k +: 64];
      b.last = (k == 3);
      bq.push_back(b);
    end
    tick();
    mm_done = 1'b0;
  endtask

  task automatic drain(input int hold);
    m_ready = 1'b0;
    repeat (hold) tick();
    for (int t = 0; t < 400 && bq.size() != 0; t++) begin
      m_ready = 1'($urandom % 2);
      tick();
    end
    m_ready = 1'b0;
    chk("drain_left", 64'(bq.size()), 64'd0);
    chk("s_ready_after_send", 64'(s_ready), 64'd1);
  endtask

  task automatic rand_rows();
    for (int i = 0; i < 8; i++) begin
      A[i] = {$urandom, $urandom};
      B[i] = {$urandom, $urandom};
    end
  endtask

  task automatic txn(input bit gaps, input logic [255:0] c, input int hold);
    int prev = starts_seen;
    load(8, gaps);
    chk("busy_after_load", 64'(busy), 64'd1);
    wait_start(prev);
    fire_done(c);
    drain(hold);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] c;
    int prev;
    // Reset state
    repeat (3) tick();
    chk("rst_s_ready", 64'(s_ready), 64'd0);
    chk("rst_mm_valid", 64'(mm_valid), 64'd0);
    chk("rst_mm_start", 64'(mm_start), 64'd0);
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_m_last", 64'(m_last), 64'd0);
    chk("rst_m_data", m_data, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    rst = 1'b1;
    repeat (2) tick();
    chk("post_rst_s_ready", 64'(s_ready), 64'd1);
    chk("post_rst_busy", 64'(busy), 64'd0);

    // Directed rows and result with backpressure
    for (int i = 0; i < 8; i++) begin
      A[i] = 64'h0101010101010101 * 64'(i + 1);
      B[i] = 64'hF000000000000000 + 64'(i);
    end
    c = {64'h4444444444444444, 64'h3333333333333333,
         64'h2222222222222222, 64'h1111111111111111};
    txn(1'b0, c, 3);

    // Randomised rows with s_valid gaps
    repeat (3) begin
      rand_rows();
      c = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      txn(1'b1, c, $urandom_range(0, 3));
    end

    // mm_done outside WAIT must not produce beats
    mm_c = {8{$urandom}};
    mm_done = 1'b1;
    tick();
    mm_done = 1'b0;
    repeat (5) tick();
    chk("idle_done_busy", 64'(busy), 64'd0);

    // Timeout: no done ever
    rand_rows();
    prev = starts_seen;
    load(8, 1'b0);
    wait_start(prev);
    while (cycle < last_start_cyc + 4095) @(negedge clk);
    chk("tmo_err_early", 64'(err), 64'd0);
    chk("tmo_s_ready_early", 64'(s_ready), 64'd0);
    @(negedge clk);
    chk("tmo_err", 64'(err), 64'd1);
    chk("tmo_s_ready", 64'(s_ready), 64'd1);
    chk("tmo_busy", 64'(busy), 64'd0);
    tick();
    rand_rows();
    c = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    txn(1'b0, c, 1);
    chk("err_sticky", 64'(err), 64'd1);

    // clr after 3rd B row
    rand_rows();
    load(3, 1'b0);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_err", 64'(err), 64'd0);
    chk("clr_busy", 64'(busy), 64'd0);
    chk("clr_s_ready", 64'(s_ready), 64'd1);
    prev = starts_seen;
    repeat (8) tick();
    chk("clr_no_start", 64'(starts_seen - prev), 64'd0);
    rand_rows();
    c = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    txn(1'b1, c, 2);

    // Reset mid-SEND
    rand_rows();
    prev = starts_seen;
    load(8, 1'b0);
    wait_start(prev);
    c = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    fire_done(c);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    rst = 1'b0;
    bq.delete();
    #1;
    chk("midrst_m_valid", 64'(m_valid), 64'd0);
    chk("midrst_m_data", m_data, 64'd0);
    chk("midrst_s_ready", 64'(s_ready), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_err", 64'(err), 64'd0);
    m_ready = 1'b1;
    repeat (2) tick();
    rst = 1'b1;
    repeat (10) tick();
    m_ready = 1'b0;
    chk("post_midrst_s_ready", 64'(s_ready), 64'd1);
    chk("post_midrst_m_valid", 64'(m_valid), 64'd0);

    chk("row_queue_empty", 64'(rq.size()), 64'd0);
    chk("beat_queue_empty", 64'(bq.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
